// File: rtl/ysyx_22050612_ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The optional YSYX_22050612_IFQ_BYPASS_EN macro enables the response-to-output bypass.
package ysyx_22050612_ifq_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StFlush = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifq_fifo.sv
// Synchronous FIFO holding fetched {inst, pc} entries; clear has priority over push/pop.
module ysyx_22050612_ifq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    input  logic                          clear,
    output logic [WIDTH-1:0]              head_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    // Storage is reset so the head (and thus inst/inst_pc) reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;

endmodule

// File: rtl/ysyx_22050612_ifq.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response buffering, redirect flush.
// Define YSYX_22050612_IFQ_BYPASS_EN to let a response reach the core in the same cycle when the queue is empty.
module ysyx_22050612_ifq
    import ysyx_22050612_ifq_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ifq_state_e      state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   drop_q;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    ifq_entry_t      push_entry;
    ifq_entry_t      head_entry;

    logic [CW:0]     in_flight;
    logic            req_en;
    logic            req_fire;
    logic            bypass;
    logic [CW-1:0]   outst_after;

    // Entries plus outstanding requests never exceed DEPTH, so every response has a slot.
    assign in_flight      = {1'b0, fifo_count} + {1'b0, outst_q};
    assign req_en         = rst && (state_q == StFetch) && (in_flight < (CW + 1)'(DEPTH));
    assign req_fire       = req_en && imem_req_ready;
    assign imem_req_valid = req_en;
    assign imem_req_addr  = fetch_pc_q;

`ifdef YSYX_22050612_IFQ_BYPASS_EN
    assign bypass = (state_q == StFetch) && !redirect_valid && fifo_empty &&
                    imem_rsp_valid && inst_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push_entry = '{inst: imem_rsp_data, pc: rsp_pc_q};
    assign fifo_push  = imem_rsp_valid && (state_q == StFetch) && !redirect_valid && !bypass;
    assign fifo_pop   = !fifo_empty && inst_ready;

    assign inst_valid = bypass || !fifo_empty;
    assign inst       = bypass ? imem_rsp_data : head_entry.inst;
    assign inst_pc    = bypass ? rsp_pc_q      : head_entry.pc;

    // A request issued in the redirect cycle is already stale; a response in that cycle is discarded.
    assign outst_after = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);

    ysyx_22050612_ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ifq_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (redirect_valid),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            outst_q <= outst_after;
            if (redirect_valid) begin
                fetch_pc_q <= align_pc(redirect_pc);
                rsp_pc_q   <= align_pc(redirect_pc);
                drop_q     <= outst_after;
                state_q    <= (outst_after != '0) ? StFlush : StFetch;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + 64'd4;
                end
                case (state_q)
                    StFetch: begin
                        if (imem_rsp_valid) begin
                            rsp_pc_q <= rsp_pc_q + 64'd4;
                        end
                    end
                    StFlush: begin
                        if (imem_rsp_valid) begin
                            drop_q <= drop_q - CW'(1);
                            if (drop_q == CW'(1)) begin
                                state_q <= StFetch;
                            end
                        end
                    end
                    default: state_q <= StFetch;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    rsp_space_a: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && fifo_full && (state_q == StFetch)));
    rsp_credit_a: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && (outst_q == '0)));
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifq.sv
// Randomized bench for ysyx_22050612_ifq against an address-stream reference model and a mock imem.
module tb_ysyx_22050612_ifq;

    localparam int unsigned  DEPTH    = 4;
    localparam logic [63:0]  RESET_PC = 64'h8000_0000;
`ifdef YSYX_22050612_IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: mock imem queue of accepted addresses, expected pc streams, stale count.
    logic [63:0] q[$];
    logic [63:0] exp_pc;
    logic [63:0] next_req;
    int          stale;
    bit          smp_inst_valid;
    bit          smp_req_valid;
    bit          smp_req_fire;
    logic [63:0] smp_req_addr;

    always #5 clk = ~clk;

    ysyx_22050612_ifq #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5eed_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        rst            = 1'b0;
        #1;
        check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_inst_pc", inst_pc, 64'd0);
        q.delete();
        stale    = 0;
        exp_pc   = RESET_PC;
        next_req = RESET_PC;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at negedge, sample 1ns later, advance the model for the coming posedge.
    task automatic step(input int pr, input int ps, input int pi, input int pd,
                        input bit fpc_en, input logic [63:0] fpc);
        bit          pop;
        logic [63:0] tgt;
        @(negedge clk);
        imem_req_ready = (int'($urandom % 100) < pr);
        imem_rsp_valid = (q.size() > 0) && (int'($urandom % 100) < ps);
        if (imem_rsp_valid) imem_rsp_data = mem_word(q[0]);
        else                imem_rsp_data = $urandom;
        inst_ready     = (int'($urandom % 100) < pi);
        redirect_valid = (int'($urandom % 100) < pd);
        if (fpc_en) begin
            redirect_pc = fpc;
        end else begin
            case ($urandom % 4)
                0:       redirect_pc = 64'hffff_ffff_ffff_fffc | 64'($urandom % 4);
                1:       redirect_pc = 64'h8000_0100;
                default: redirect_pc = {$urandom, $urandom};
            endcase
        end
        #1;
        smp_inst_valid = inst_valid;
        smp_req_valid  = imem_req_valid;
        smp_req_addr   = imem_req_addr;
        smp_req_fire   = imem_req_valid && imem_req_ready;
        pop            = inst_valid && inst_ready;
        if (stale > 0) check_eq("req_during_drain", 64'(imem_req_valid), 64'd0);
        if (smp_req_fire) check_eq("req_addr", imem_req_addr, next_req);
        if (pop) begin
            check_eq("inst_pc", inst_pc, exp_pc);
            check_eq("inst", 64'(inst), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 64'd4;
        end
        if (imem_rsp_valid) begin
            void'(q.pop_front());
            if (stale > 0) stale--;
        end
        if (smp_req_fire) begin
            q.push_back(imem_req_addr);
            next_req = next_req + 64'd4;
        end
        if (redirect_valid) begin
            tgt      = {redirect_pc[63:2], 2'b00};
            exp_pc   = tgt;
            next_req = tgt;
            stale    = q.size();
        end
        check_eq("credit_bound", 64'(q.size() <= DEPTH), 64'd1);
    endtask

    initial begin
        int fires;

        // Reset release and back-to-back streaming without gaps.
        do_reset();
        step(0, 0, 0, 0, 1'b0, '0);
        check_eq("first_req_valid", 64'(smp_req_valid), 64'd1);
        check_eq("first_req_addr", smp_req_addr, RESET_PC);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(100, 100, 100, 0, 1'b0, '0);
            if (i >= 2) check_eq("no_gap", 64'(smp_inst_valid), 64'd1);
        end

        // Stalled consumer: exactly DEPTH requests, then drain in order.
        do_reset();
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            step(100, 100, 0, 0, 1'b0, '0);
            if (smp_req_fire) fires++;
        end
        check_eq("req_cap", 64'(fires), 64'(DEPTH));
        check_eq("req_stall", 64'(smp_req_valid), 64'd0);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 1'b0, '0);

        // Redirect with two requests outstanding.
        do_reset();
        step(100, 0, 0, 0, 1'b0, '0);
        step(100, 0, 0, 0, 1'b0, '0);
        step(0, 0, 0, 100, 1'b1, 64'h8000_0100);
        step(100, 100, 100, 0, 1'b0, '0);
        check_eq("empty_after_redirect", 64'(smp_inst_valid), 64'd0);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 1'b0, '0);

        // Redirect together with a pop and a response.
        do_reset();
        for (int i = 0; i < 3; i++) step(100, 0, 0, 0, 1'b0, '0);
        step(0, 100, 0, 0, 1'b0, '0);
        step(0, 100, 100, 100, 1'b1, 64'h8000_0200);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 1'b0, '0);

        // Fetch address wrap.
        do_reset();
        step(0, 0, 0, 100, 1'b1, 64'hffff_ffff_ffff_ffff);
        step(100, 0, 0, 0, 1'b0, '0);
        step(100, 0, 0, 0, 1'b0, '0);
        check_eq("wrap_addr", smp_req_addr, 64'd0);
        for (int i = 0; i < 6; i++) step(0, 100, 100, 0, 1'b0, '0);

        // Latency from response to inst_valid on an empty queue.
        do_reset();
        step(100, 0, 0, 0, 1'b0, '0);
        step(0, 100, 100, 0, 1'b0, '0);
        check_eq("rsp_latency", 64'(smp_inst_valid), 64'(BYP));
        step(0, 100, 100, 0, 1'b0, '0);
        check_eq("post_latency", 64'(smp_inst_valid), 64'(!BYP));

        // Randomized traffic with redirects and occasional mid-burst resets.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            int pr, ps, pi, pd;
            pr = int'($urandom_range(30, 100));
            ps = int'($urandom_range(20, 100));
            pi = int'($urandom_range(10, 100));
            pd = int'($urandom_range(0, 8));
            for (int i = 0; i < 80; i++) step(pr, ps, pi, pd, 1'b0, '0);
            if (r % 10 == 9) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
